des_block_fifo: RTL and testbench
=================================

Name: des_block_fifo

Overview:
- Input buffer in front of the DES pipeline. It accepts 64-bit plaintext/ciphertext blocks from the host side over a valid/ready handshake.
- Blocks are stored in order in a small circular buffer. Each one is presented to the first pipeline register together with a one-bit advance qualifier.
- Absorbs host burstiness and pipeline stalls so that no block is lost or duplicated.

Parameters:
- WIDTH, 64, block width in bits; bit 0 is the MSB, matching the pipeline registers.
- DEPTH, 4, number of storage entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- res  input  1  synchronous active-low reset; sampled on rising edge of clk.
- in_data  input  [0:WIDTH-1]  incoming block.
- in_valid  input  1  in_data holds a block.
- in_ready  output  1  buffer can accept a block this cycle.
- out_data  output  [0:WIDTH-1]  head block; drives the first pipeline register input.
- out_valid  output  1  out_data holds a valid block; drives the first pipeline register enable, qualified by out_ready.
- out_ready  input  1  pipeline advances this cycle.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on res. When res=0 at a rising edge: write pointer, read pointer and count go to 0; out_valid=0; out_data=0.
  - Storage array contents are not cleared.
  - While res=0, in_ready=0 combinationally and no push or pop occurs.
- Handshake:
  - Push when in_valid & in_ready at a rising edge.
  - Pop when out_valid & out_ready at a rising edge.
  - in_valid/in_data must hold until accepted. out_valid/out_data hold until popped.
- Flags:
  - in_ready = res & (count != DEPTH), decoded from registered count only.
  - No combinational path from out_ready to in_ready, so a full buffer does not accept a push in the same cycle as a pop.
- Output register:
  - out_data/out_valid are registered. Their next value is the head entry after the current push/pop.
  - Latency: a block pushed into an empty buffer appears on out_data with out_valid=1 exactly one cycle after acceptance. Lookahead read, no bubble.
  - Back-to-back pops stream one block per cycle while count>1 or a push refills the buffer.
- Pointers and count:
  - Pointers are AW bits and wrap modulo DEPTH naturally.
  - count is AW+1 bits, range 0..DEPTH.
  - Push only: count+1. Pop only: count-1. Push and pop together: count unchanged, both pointers advance.
- Boundary conditions:
  - Empty: out_valid=0. out_data holds its last value; it is 0 after reset.
  - Empty with push: the entry is written and out_valid rises next cycle.
  - Count=1 with push and pop together: the popped entry leaves and the new entry is on out_data next cycle, with out_valid staying 1.
  - Full: in_ready=0 and any in_valid is ignored. A pop frees a slot and in_ready rises next cycle.
  - Reset mid-operation: all buffered blocks are discarded and the first post-reset push behaves as on an empty buffer.
- Data order is strict FIFO. No data transformation is performed.

Optional Feature:
- Macro: DES_FIFO_LEVEL_EN.
- When defined:
  - Adds output port level [AW:0], which equals the registered count.
  - Adds sticky output overflow_seen (1 bit): set when in_valid=1 while count==DEPTH; cleared only by reset.
- When undefined: neither port nor its logic exists; the rest of the behaviour is identical.

Test Plan:
- Reset then idle: res=0 for 2 cycles, then res=1 -> out_valid=0, out_data=0, in_ready=0 during reset and 1 afterwards.
- Single block: push 0x0123456789ABCDEF with out_ready=0 -> next cycle out_valid=1 and out_data=0x0123456789ABCDEF. Assert out_ready for 1 cycle -> out_valid=0 on the next cycle.
- Fill to full: out_ready=0, push 0x1,0x2,0x3,0x4 -> in_ready=0 after the 4th push. A 5th block 0x5 held valid is not accepted. One pop -> in_ready=1 next cycle, 0x5 accepted, pop order 1,2,3,4,5.
- Streaming: in_valid=1 and out_ready=1 continuously for 20 blocks 0x10..0x23 -> one block out per cycle after 1-cycle latency, count stays at 1, and pointers wrap at least 4 times with order preserved.
- Reset mid-operation: 3 blocks buffered, res=0 for 1 cycle -> out_valid=0, count=0. Push 0xAA -> out_data=0xAA next cycle; no stale block appears.
- With DES_FIFO_LEVEL_EN: fill to 4 and keep in_valid=1 -> level=4 and overflow_seen=1. It stays 1 after draining and clears only on res=0.

Source files
------------

// File: rtl/des_block_fifo.sv
// Input block FIFO in front of the DES pipeline, with a registered lookahead head output.
// Define DES_FIFO_LEVEL_EN to add the level and overflow_seen status outputs.
module des_block_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             res,
  input  logic [0:WIDTH-1] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [0:WIDTH-1] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DES_FIFO_LEVEL_EN
  ,
  output logic [AW:0]      level,
  output logic             overflow_seen
`endif
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [0:WIDTH-1] mem_q [DEPTH];
  logic [0:WIDTH-1] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [0:WIDTH-1] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop;

  // in_ready depends only on registered count, never on out_ready.
  assign in_ready  = res & (count_q != CNT_FULL);
  assign push      = in_valid & in_ready;
  assign pop       = res & out_valid_q & out_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_data_d = out_data_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Reading the post-write array makes a same-cycle push into an empty
    // (or just-emptied) buffer appear on the next cycle without a bubble.
    out_valid_d = (count_d != '0);
    if (out_valid_d) begin
      out_data_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef DES_FIFO_LEVEL_EN
  logic overflow_seen_q, overflow_seen_d;

  always_comb begin
    overflow_seen_d = overflow_seen_q | (in_valid & (count_q == CNT_FULL));
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      overflow_seen_q <= 1'b0;
    end else begin
      overflow_seen_q <= overflow_seen_d;
    end
  end

  assign level         = count_q;
  assign overflow_seen = overflow_seen_q;
`endif

endmodule

// File: tb/tb_des_block_fifo.sv
// Bench for des_block_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_des_block_fifo;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             res;
  logic [0:WIDTH-1] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [0:WIDTH-1] out_data;
  logic             out_valid;
  logic             out_ready;
`ifdef DES_FIFO_LEVEL_EN
  logic [AW:0]      level;
  logic             overflow_seen;
`endif

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  bit          chk_en  = 1'b0;

  always #5 clk = ~clk;

  des_block_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .res       (res),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DES_FIFO_LEVEL_EN
    ,
    .level         (level),
    .overflow_seen (overflow_seen)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of blocks; the head is what must be shown.
  logic [63:0] mq[$];
  logic [63:0] m_last = '0;
  bit          m_ovf  = 1'b0;
  bit          m_push = 1'b0;

  always @(posedge clk) begin
    bit p_in, p_out;
    m_push = 1'b0;
    if (!res) begin
      mq.delete();
      m_last = '0;
      m_ovf  = 1'b0;
    end else begin
      p_in  = in_valid && (mq.size() != DEPTH);
      p_out = out_ready && (mq.size() != 0);
      if (in_valid && mq.size() == DEPTH) m_ovf = 1'b1;
      if (p_out) void'(mq.pop_front());
      if (p_in) mq.push_back(in_data);
      m_push = p_in;
      if (mq.size() != 0) m_last = mq[0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  in_ready,  res && (mq.size() != DEPTH));
      check("out_valid", out_valid, mq.size() != 0);
      check("out_data",  out_data,  m_last);
`ifdef DES_FIFO_LEVEL_EN
      check("level",         level,         mq.size());
      check("overflow_seen", overflow_seen, m_ovf);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    res = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset then idle
    step(); chk_en = 1'b1; step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 64'h0);
    res = 1'b1; #1;
    check("idle_in_ready", in_ready, 1'b1);

    // Single block
    in_data = 64'h0123456789ABCDEF; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, 64'h0123456789ABCDEF);
    out_ready = 1'b1;
    step(); out_ready = 1'b0;
    check("single_popped", out_valid, 1'b0);
    check("single_hold", out_data, 64'h0123456789ABCDEF);

    // Fill to full, held 5th block, then drain in order
    for (int v = 1; v <= 4; v++) begin
      in_data = 64'(v); in_valid = 1'b1; step();
    end
    check("full_in_ready", in_ready, 1'b0);
    in_data = 64'h5;
    step(); step();
    check("full_still", in_ready, 1'b0);
    check("full_head", out_data, 64'h1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("free_in_ready", in_ready, 1'b1);
    check("free_head", out_data, 64'h2);
    step(); in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check("drain_valid", out_valid, 1'b1);
      check("drain_data", out_data, 64'(k));
      step();
    end
    out_ready = 1'b0;
    check("drain_empty", out_valid, 1'b0);

    // Streaming with pointer wrap
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 64'(16 + i);
      step();
      check("stream_data", out_data, 64'(16 + i));
`ifdef DES_FIFO_LEVEL_EN
      check("stream_level", level, 3'd1);
`endif
    end
    in_valid = 1'b0; step(); out_ready = 1'b0;
    check("stream_end_valid", out_valid, 1'b0);
    check("stream_end_hold", out_data, 64'h23);

    // Reset mid-operation
    for (int v = 0; v < 3; v++) begin
      in_data = 64'(49 + v); in_valid = 1'b1; step();
    end
    in_valid = 1'b0; res = 1'b0; step(); res = 1'b1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 64'h0);
    in_data = 64'hAA; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_data", out_data, 64'hAA);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("no_stale", out_valid, 1'b0);

`ifdef DES_FIFO_LEVEL_EN
    for (int v = 0; v < 4; v++) begin
      in_data = 64'(112 + v); in_valid = 1'b1; step();
    end
    in_data = 64'h99; step();
    check("lvl_full", level, 3'd4);
    check("ovf_set", overflow_seen, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    check("lvl_empty", level, 3'd0);
    check("ovf_sticky", overflow_seen, 1'b1);
    res = 1'b0; step(); res = 1'b1;
    check("ovf_cleared", overflow_seen, 1'b0);
`endif

    // Randomized traffic with protocol-respecting input hold
    for (int c = 0; c < 3000; c++) begin
      if (!(in_valid && !m_push && res)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 2) != 0);
      res       = ($urandom_range(0, 99) != 0);
      step();
    end
    res = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
